// File: rtl/operand_fetch_pkg.sv
// Core-wide sizing shared by operand fetch and the register file.
// Register index width, data width and register count live here so both sides agree.
package operand_fetch_pkg;

  localparam int unsigned CoreRegWidth = 5;
  localparam int unsigned CoreWidth    = 32;
  localparam int unsigned CoreRegCount = 1 << CoreRegWidth;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits tracking outstanding writes, with two read-side query ports.
// Register 0 is hardwired not-busy; a set beats a clear on the same index; flush clears all.
module reg_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int unsigned RegWidth = CoreRegWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                set_en_i,
  input  logic [RegWidth-1:0] set_idx_i,
  input  logic                clr_en_i,
  input  logic [RegWidth-1:0] clr_idx_i,
  input  logic                flush_i,
  input  logic [RegWidth-1:0] query_a_idx_i,
  input  logic [RegWidth-1:0] query_b_idx_i,
  output logic                query_a_busy_o,
  output logic                query_b_busy_o
);

  localparam int unsigned NumRegs = 1 << RegWidth;

  logic [NumRegs-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    // Set is applied after clear so a same-cycle reissue keeps the register busy.
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
    if (flush_i) busy_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign query_a_busy_o = busy_q[query_a_idx_i];
  assign query_b_busy_o = busy_q[query_b_idx_i];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources, stalls on scoreboard hazards, registers the operand bundle.
// Define OPERAND_FORWARD_EN to bypass same-cycle writeback data into the operands.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned REG_WIDTH = CoreRegWidth,
  parameter int unsigned WIDTH     = CoreWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] in_rs1,
  input  logic [REG_WIDTH-1:0] in_rs2,
  input  logic [REG_WIDTH-1:0] in_rd,
  input  logic                 in_rd_wen,
  output logic [REG_WIDTH-1:0] rs1_offset,
  output logic [REG_WIDTH-1:0] rs2_offset,
  input  logic [WIDTH-1:0]     rs1_data,
  input  logic [WIDTH-1:0]     rs2_data,
  input  logic                 wb_valid,
  input  logic [REG_WIDTH-1:0] wb_rd,
  input  logic [WIDTH-1:0]     wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_op1,
  output logic [WIDTH-1:0]     out_op2,
  output logic [REG_WIDTH-1:0] out_rd,
  output logic                 out_rd_wen
);

  logic                 busy_rs1, busy_rs2;
  logic                 fwd_rs1, fwd_rs2;
  logic                 hazard, accept;
  logic                 set_en, clr_en;
  logic [WIDTH-1:0]     op1_sel, op2_sel;

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     op1_q, op1_d, op2_q, op2_d;
  logic [REG_WIDTH-1:0] rd_q, rd_d;
  logic                 rd_wen_q, rd_wen_d;

  assign rs1_offset = in_rs1;
  assign rs2_offset = in_rs2;

`ifdef OPERAND_FORWARD_EN
  assign fwd_rs1 = wb_valid && (wb_rd == in_rs1);
  assign fwd_rs2 = wb_valid && (wb_rd == in_rs2);
`else
  assign fwd_rs1 = 1'b0;
  assign fwd_rs2 = 1'b0;
`endif

  assign hazard = ((in_rs1 != '0) && busy_rs1 && !fwd_rs1) ||
                  ((in_rs2 != '0) && busy_rs2 && !fwd_rs2);

  assign in_ready = rst && (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign set_en   = accept && in_rd_wen && (in_rd != '0);
  assign clr_en   = wb_valid && (wb_rd != '0);

  reg_scoreboard #(
    .RegWidth (REG_WIDTH)
  ) u_scoreboard (
    .clk_i          (clk),
    .rst_ni         (rst),
    .set_en_i       (set_en),
    .set_idx_i      (in_rd),
    .clr_en_i       (clr_en),
    .clr_idx_i      (wb_rd),
    .flush_i        (flush),
    .query_a_idx_i  (in_rs1),
    .query_b_idx_i  (in_rs2),
    .query_a_busy_o (busy_rs1),
    .query_b_busy_o (busy_rs2)
  );

  always_comb begin
    op1_sel = fwd_rs1 ? wb_data : rs1_data;
    op2_sel = fwd_rs2 ? wb_data : rs2_data;
    if (in_rs1 == '0) op1_sel = '0;
    if (in_rs2 == '0) op2_sel = '0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    rd_d        = rd_q;
    rd_wen_d    = rd_wen_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      op1_d       = op1_sel;
      op2_d       = op2_sel;
      rd_d        = in_rd;
      rd_wen_d    = in_rd_wen;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_q        <= '0;
      rd_wen_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rd_q        <= rd_d;
      rd_wen_q    <= rd_wen_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_op1    = op1_q;
  assign out_op2    = op2_q;
  assign out_rd     = rd_q;
  assign out_rd_wen = rd_wen_q;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter WIDTH, default 32, data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  decode presents an instruction.
REQ-006 SHALL have port in_ready  output  1  fetch accepts an instruction this cycle.
REQ-007 SHALL have ports in_rs1, in_rs2, in_rd  input  REG_WIDTH each  source and destination indices.
REQ-008 SHALL have port in_rd_wen  input  1  the instruction will write rd.
REQ-009 SHALL have ports rs1_offset, rs2_offset  output  REG_WIDTH each  register-file read indices.
REQ-010 SHALL have ports rs1_data, rs2_data  input  WIDTH each  register-file combinational read data.
REQ-011 SHALL have ports wb_valid  input  1, wb_rd  input  REG_WIDTH, and wb_data  input  WIDTH  writeback commit, also driven to the register file.
REQ-012 SHALL have port flush  input  1  discard in-flight state.
REQ-013 SHALL have ports out_valid  output  1 and out_ready  input  1  execute-side handshake.
REQ-014 SHALL have ports out_op1, out_op2  output  WIDTH, out_rd  output  REG_WIDTH, and out_rd_wen  output  1  the registered operand bundle.

Function
REQ-015 SHALL drive rs1_offset=in_rs1 and rs2_offset=in_rs2 combinationally.
REQ-016 SHALL keep a busy bit per register (2^REG_WIDTH bits); bit 0 is always 0.
REQ-017 SHALL define a hazard as busy[in_rs1] or busy[in_rs2], with index 0 excluded.
REQ-018 SHALL assert in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-019 SHALL accept on in_valid && in_ready, and load the output bundle on the next posedge (latency 1 cycle), setting out_valid=1.
REQ-020 SHALL make an operand with source index 0 equal to 0, regardless of rs*_data.
REQ-021 SHALL, on accept with in_rd_wen=1 and in_rd!=0, set busy[in_rd].
REQ-022 SHALL, on wb_valid with wb_rd!=0, clear busy[wb_rd]; wb_rd=0 is ignored.
REQ-023 SHALL let set win when a set and a clear hit the same index in the same cycle.
REQ-024 SHALL hold the output bundle stable while out_valid && !out_ready.
REQ-025 SHALL clear out_valid when out_valid && out_ready and there is no new accept.
REQ-026 SHALL, on flush=1 at posedge, clear out_valid and all busy bits; flush overrides a concurrent accept and writeback.

Reset
REQ-027 SHALL, while rst=0, immediately force out_valid=0, all busy bits=0, out_op1=0, out_op2=0, out_rd=0, and out_rd_wen=0.
REQ-028 SHALL keep in_ready=0 while rst=0; the first accept is possible on the first posedge after rst rises.

Configuration
REQ-029 SHALL, with macro OPERAND_FORWARD_EN defined, exclude a source from the hazard when wb_valid && wb_rd equals that source, and take wb_data as the operand.
REQ-030 SHALL, without OPERAND_FORWARD_EN, stall on busy sources regardless of a same-cycle writeback, and take operands only from rs*_data; a stalled instruction is accepted in the cycle after the writeback.

Structure
REQ-031 SHALL take REG_WIDTH, WIDTH, and REG_COUNT defaults from a shared core package, shared with the register file.
REQ-032 SHALL implement the busy bits in one sub-module, reg_scoreboard, with set/clear/flush inputs and two query ports.

Verification
REQ-033 SHALL test: reset release, then in rs1=1, rs2=2, rd=3 with rs1_data=5, rs2_data=7 -> one cycle later out_op1=5, out_op2=7, out_rd=3, and busy[3] set.
REQ-034 SHALL test: issue rd=3, then issue rs1=3 with no writeback -> in_ready=0 until wb_rd=3 is committed; with FORWARD_EN, wb_data=0xDEAD in the same cycle gives out_op1=0xDEAD with no extra stall.
REQ-035 SHALL test: rs1=0 with rs1_data=0xFFFFFFFF, and issue rd=0 -> out_op1=0, and busy[0] is never set.
REQ-036 SHALL test: out_ready=0 for 3 cycles with out_valid=1 -> bundle unchanged and in_ready=0; the bundle is consumed on the first out_ready=1.
REQ-037 SHALL test: same-cycle accept rd=4 and wb_rd=4 -> busy[4]=1 afterwards.
REQ-038 SHALL test: flush with out_valid=1 and busy[5]=1 -> next cycle out_valid=0, busy all 0; rst=0 mid-stall -> outputs 0 without waiting for a clock edge.
